// File: rtl/code_decoder_monitor.sv
// ---------------------------------------------------------------------------
// code_decoder_monitor
//   Consumer of the 7-bit Gray / one-hot code bus from the 3-bit encoder.
//   Each valid sample is checked against the legal code table and decoded
//   back to 3 bits. A decoded value is published only after STABLE_CYCLES
//   identical legal samples. Illegal codes pulse err and bump a saturating
//   counter. In Gray mode a publish that is not a +/-1 step (mod 8) pulses
//   jump.
//
// Parameters
//   USE_GRAY      1 = Gray table, 0 = one-hot table
//   STABLE_CYCLES consecutive identical legal samples needed (1..15)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   code_in    [6:0] code word, sampled when in_vld=1
//   in_vld     sample qualifier
//   clr_err    synchronous clear of err_cnt (wins over an illegal sample)
//   value_out  [2:0] last published decoded value
//   upd        one-cycle pulse, value_out was just published
//   locked     level, FSM is in LOCKED
//   err        one-cycle pulse, the last sample was illegal
//   jump       one-cycle pulse with upd, non-adjacent step (Gray only)
//   err_cnt    [7:0] illegal sample count, saturates at 255
// ---------------------------------------------------------------------------
module code_decoder_monitor #(
   parameter int unsigned USE_GRAY      = 1,
   parameter int unsigned STABLE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] code_in,
   input  logic       in_vld,
   input  logic       clr_err,
   output logic [2:0] value_out,
   output logic       upd,
   output logic       locked,
   output logic       err,
   output logic       jump,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      LOCKED = 2'd2
   } state_e;

   localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);
   localparam logic       GRAY_MODE  = (USE_GRAY != 0);
   localparam logic       ONE_SHOT   = (STABLE_CYCLES == 1);

   state_e     state_q, state_d;
   logic [2:0] cand_q, cand_d;
   logic [3:0] cnt_q, cnt_d;
   logic       had_prev_q, had_prev_d;
   logic [2:0] value_q, value_d;
   logic       upd_q, upd_d;
   logic       err_q, err_d;
   logic       jump_q, jump_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   logic       legal;
   logic [2:0] dec;
   logic       publish;
   logic       err_hit;

   // ------------------------------------------------------------------------
   // Code table lookup
   // ------------------------------------------------------------------------
   always_comb begin
      legal = 1'b0;
      dec   = '0;
      if (GRAY_MODE) begin
         case (code_in)
            7'b0000000: begin legal = 1'b1; dec = 3'd0; end
            7'b0000001: begin legal = 1'b1; dec = 3'd1; end
            7'b0000011: begin legal = 1'b1; dec = 3'd2; end
            7'b0000010: begin legal = 1'b1; dec = 3'd3; end
            7'b0000110: begin legal = 1'b1; dec = 3'd4; end
            7'b0000111: begin legal = 1'b1; dec = 3'd5; end
            7'b0000101: begin legal = 1'b1; dec = 3'd6; end
            7'b0000100: begin legal = 1'b1; dec = 3'd7; end
            default:    begin legal = 1'b0; dec = 3'd0; end
         endcase
      end else begin
         if (code_in == 7'b0000000) begin
            legal = 1'b1;
         end
         // value k is carried on bit k-1
         for (int unsigned k = 0; k < 7; k++) begin
            if (code_in == (7'd1 << k)) begin
               legal = 1'b1;
               dec   = 3'(k + 1);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      publish = 1'b0;
      err_hit = 1'b0;
      if (in_vld) begin
         if (!legal) begin
            err_hit = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  cand_d = dec;
                  cnt_d  = 4'd1;
                  if (ONE_SHOT) begin
                     publish = 1'b1;
                     state_d = LOCKED;
                  end else begin
                     state_d = SETTLE;
                  end
               end
               SETTLE: begin
                  if (dec == cand_q) begin
                     cnt_d = cnt_q + 4'd1;
                     if ((cnt_q + 4'd1) == STABLE_LIM) begin
                        publish = 1'b1;
                        state_d = LOCKED;
                     end
                  end else begin
                     cand_d = dec;
                     cnt_d  = 4'd1;
                  end
               end
               LOCKED: begin
                  if (dec != value_q) begin
                     cand_d = dec;
                     cnt_d  = 4'd1;
                     if (ONE_SHOT) begin
                        publish = 1'b1;
                     end else begin
                        state_d = SETTLE;
                     end
                  end
               end
               default: begin
                  state_d = IDLE;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM: output / datapath next values
   // ------------------------------------------------------------------------
   always_comb begin
      value_d    = publish ? cand_d : value_q;
      upd_d      = publish;
      err_d      = err_hit;
      had_prev_d = had_prev_q | publish;
      // 7<->0 is adjacent through 3-bit wraparound of the +/-1 terms
      jump_d     = publish && GRAY_MODE && had_prev_q &&
                   (cand_d != (value_q + 3'd1)) &&
                   (cand_d != (value_q - 3'd1));
      if (clr_err) begin
         err_cnt_d = '0;
      end else if (err_hit && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q     <= '0;
         cnt_q      <= '0;
         had_prev_q <= 1'b0;
         value_q    <= '0;
         upd_q      <= 1'b0;
         err_q      <= 1'b0;
         jump_q     <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         had_prev_q <= had_prev_d;
         value_q    <= value_d;
         upd_q      <= upd_d;
         err_q      <= err_d;
         jump_q     <= jump_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign value_out = value_q;
   assign upd       = upd_q;
   assign locked    = (state_q == LOCKED);
   assign err       = err_q;
   assign jump      = jump_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_code_decoder_monitor.sv
// ---------------------------------------------------------------------------
// tb_code_decoder_monitor
//   Drives two instances from shared inputs: A (Gray, 3 stable samples) and
//   B (one-hot, 1 stable sample). Expected outputs are queued when a vector
//   is driven and compared one cycle later against the selected instance.
// ---------------------------------------------------------------------------
module tb_code_decoder_monitor;

   typedef struct {
      int         id;
      logic [6:0] code;
      logic       vld;
      logic       clr;
      logic [2:0] val;
      logic       upd;
      logic       lk;
      logic       er;
      logic       jp;
      logic [7:0] ec;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [6:0] code_in;
   logic       in_vld;
   logic       clr_err;

   logic [2:0] a_val, b_val;
   logic       a_upd, b_upd, a_lk, b_lk, a_err, b_err, a_jmp, b_jmp;
   logic [7:0] a_ec, b_ec;

   int   checks   = 0;
   int   failures = 0;
   logic sel      = 1'b0;

   vec_t exp_q[$];
   vec_t tab[$];
   vec_t mon_e;

   code_decoder_monitor #(.USE_GRAY(1), .STABLE_CYCLES(3)) u_gray (
      .clk(clk), .rst_n(rst_n), .code_in(code_in), .in_vld(in_vld),
      .clr_err(clr_err), .value_out(a_val), .upd(a_upd), .locked(a_lk),
      .err(a_err), .jump(a_jmp), .err_cnt(a_ec)
   );

   code_decoder_monitor #(.USE_GRAY(0), .STABLE_CYCLES(1)) u_onehot (
      .clk(clk), .rst_n(rst_n), .code_in(code_in), .in_vld(in_vld),
      .clr_err(clr_err), .value_out(b_val), .upd(b_upd), .locked(b_lk),
      .err(b_err), .jump(b_jmp), .err_cnt(b_ec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(int id, logic [6:0] c, logic v, logic cl,
                               logic [2:0] val, logic u, logic l, logic e,
                               logic j, logic [7:0] ec);
      vec_t r;
      r.id = id; r.code = c; r.vld = v; r.clr = cl; r.val = val;
      r.upd = u; r.lk = l; r.er = e; r.jp = j; r.ec = ec;
      return r;
   endfunction

   function automatic logic [14:0] pack_act();
      if (sel) return {b_val, b_upd, b_lk, b_err, b_jmp, b_ec};
      else     return {a_val, a_upd, a_lk, a_err, a_jmp, a_ec};
   endfunction

   // scoreboard consumer: outputs are visible just after the sampling edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [14:0] act, expv;
         mon_e = exp_q.pop_front();
         act   = pack_act();
         expv  = {mon_e.val, mon_e.upd, mon_e.lk, mon_e.er, mon_e.jp, mon_e.ec};
         checks++;
         if (act !== expv) begin
            failures++;
            $display("FAIL vec%0d dut=%0d: got val=%0d upd=%b lk=%b err=%b jmp=%b ecnt=%0d, want val=%0d upd=%b lk=%b err=%b jmp=%b ecnt=%0d",
                     mon_e.id, sel, act[14:12], act[11], act[10], act[9], act[8], act[7:0],
                     expv[14:12], expv[11], expv[10], expv[9], expv[8], expv[7:0]);
         end
      end
   end

   task automatic drive(input vec_t v);
      @(negedge clk);
      code_in = v.code;
      in_vld  = v.vld;
      clr_err = v.clr;
      exp_q.push_back(v);
   endtask

   task automatic run_tab();
      for (int i = 0; i < tab.size(); i++) drive(tab[i]);
      tab.delete();
   endtask

   task automatic drain();
      int n;
      @(negedge clk);
      in_vld  = 1'b0;
      clr_err = 1'b0;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic chk_zero(input string name);
      logic [14:0] act;
      act = pack_act();
      checks++;
      if (act !== 15'd0) begin
         failures++;
         $display("FAIL %s: got %h, want 0000", name, act);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ec;
      rst_n   = 1'b0;
      code_in = '0;
      in_vld  = 1'b0;
      clr_err = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset_gray");
      rst_n = 1'b1;

      // ---- Gray, STABLE_CYCLES=3 ----
      tab.push_back(mk( 1, 7'b0000011, 1, 0, 3'd0, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk( 2, 7'b0000011, 1, 0, 3'd0, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk( 3, 7'b1111111, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk( 4, 7'b0000011, 1, 0, 3'd2, 1, 1, 0, 0, 8'd0));
      tab.push_back(mk( 5, 7'b0000010, 1, 0, 3'd2, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk( 6, 7'b0000010, 1, 0, 3'd2, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk( 7, 7'b0000010, 1, 0, 3'd3, 1, 1, 0, 0, 8'd0));
      tab.push_back(mk( 8, 7'b0000101, 1, 0, 3'd3, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk( 9, 7'b0000101, 1, 0, 3'd3, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk(10, 7'b0000101, 1, 0, 3'd6, 1, 1, 0, 1, 8'd0));
      tab.push_back(mk(11, 7'b0000100, 1, 0, 3'd6, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk(12, 7'b0000100, 1, 0, 3'd6, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk(13, 7'b0000100, 1, 0, 3'd7, 1, 1, 0, 0, 8'd0));
      tab.push_back(mk(14, 7'b0000000, 1, 0, 3'd7, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk(15, 7'b0000000, 1, 0, 3'd7, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk(16, 7'b0000000, 1, 0, 3'd0, 1, 1, 0, 0, 8'd0));
      tab.push_back(mk(17, 7'b0000001, 1, 0, 3'd0, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk(18, 7'b0000001, 1, 0, 3'd0, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk(19, 7'b0000111, 1, 0, 3'd0, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk(20, 7'b0000111, 1, 0, 3'd0, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk(21, 7'b0000111, 1, 0, 3'd5, 1, 1, 0, 1, 8'd0));
      tab.push_back(mk(22, 7'b1010000, 1, 0, 3'd5, 0, 0, 1, 0, 8'd1));
      run_tab();

      // saturation of the error counter
      ec = 8'd1;
      for (int i = 0; i < 300; i++) begin
         if (ec != 8'hFF) ec = ec + 8'd1;
         drive(mk(100 + i, 7'b1010000, 1, 0, 3'd5, 0, 0, 1, 0, ec));
      end
      tab.push_back(mk(23, 7'b1010000, 1, 1, 3'd5, 0, 0, 1, 0, 8'd0));
      tab.push_back(mk(24, 7'b1010000, 1, 0, 3'd5, 0, 0, 1, 0, 8'd1));
      tab.push_back(mk(25, 7'b0000110, 1, 0, 3'd5, 0, 0, 0, 0, 8'd1));
      tab.push_back(mk(26, 7'b0000110, 1, 0, 3'd5, 0, 0, 0, 0, 8'd1));
      run_tab();
      drain();

      // asynchronous reset while settling (cnt=2)
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_reset_gray");
      @(negedge clk);
      rst_n = 1'b1;
      tab.push_back(mk(27, 7'b0000110, 1, 0, 3'd0, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk(28, 7'b0000110, 1, 0, 3'd0, 0, 0, 0, 0, 8'd0));
      tab.push_back(mk(29, 7'b0000110, 1, 0, 3'd4, 1, 1, 0, 0, 8'd0));
      run_tab();
      drain();

      // ---- one-hot, STABLE_CYCLES=1 ----
      rst_n = 1'b0;
      @(negedge clk);
      sel = 1'b1;
      chk_zero("reset_onehot");
      rst_n = 1'b1;
      tab.push_back(mk(40, 7'b0100000, 1, 0, 3'd6, 1, 1, 0, 0, 8'd0));
      tab.push_back(mk(41, 7'b0000011, 1, 0, 3'd6, 0, 0, 1, 0, 8'd1));
      tab.push_back(mk(42, 7'b0000000, 1, 0, 3'd0, 1, 1, 0, 0, 8'd1));
      tab.push_back(mk(43, 7'b0001000, 1, 0, 3'd4, 1, 1, 0, 0, 8'd1));
      tab.push_back(mk(44, 7'b0001000, 1, 0, 3'd4, 0, 1, 0, 0, 8'd1));
      tab.push_back(mk(45, 7'b0000000, 0, 0, 3'd4, 0, 1, 0, 0, 8'd1));
      tab.push_back(mk(46, 7'b1000000, 1, 0, 3'd7, 1, 1, 0, 0, 8'd1));
      tab.push_back(mk(47, 7'b1000000, 0, 1, 3'd7, 0, 1, 0, 0, 8'd0));
      run_tab();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
